// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states, config
// encodings and the FIFO entry layout.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // FIFO entry is {ferr, perr, data}; flags sit above the data field.
  localparam int ENT_FLAG_BITS = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO with no
// simultaneous pop is dropped and reported as a one-cycle overrun.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, wr_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = !empty;
  assign pop     = valid && ready;
  // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr's slot.
  assign wr_en   = push && (!full || pop);
  assign overrun = push && full && !pop;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with majority-of-3 sampling, break
// detection and an output FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [3:0]            data_bits,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  stop_bits,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  overrun,
  output logic                  break_det
);
  localparam int EW = DATA_WIDTH + ENT_FLAG_BITS;

  logic                  sync1, rx;
  state_t                state, state_nx;
  logic [PRESC_W-1:0]    edge_cnt, edge_nx, presc_q, half, smp_lo, smp_hi, last_edge;
  logic [3:0]            bit_cnt, bit_nx, nbits_q;
  logic                  par_en_q, par_type_q, stop2_q, latch;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic                  s_a, s_b, maj, decide, bit_end;
  logic                  perr_q, perr_nx, ferr_q, ferr_nx, zero_q, zero_nx;
  logic                  push;
  logic [EW-1:0]         push_entry, head;

  assign half      = presc_q >> 1;
  assign smp_lo    = half - 1'b1;
  assign smp_hi    = half + 1'b1;
  assign last_edge = presc_q - 1'b1;
  assign decide    = (edge_cnt == smp_hi);
  assign bit_end   = (edge_cnt == last_edge);
  assign maj       = (s_a & s_b) | (s_a & rx) | (s_b & rx);
  assign push_entry = {ferr_q | ~maj, perr_q, shreg};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1    <= 1'b1;
      rx       <= 1'b1;
      state    <= S_IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      sync1    <= RX_IN;
      rx       <= sync1;
      state    <= state_nx;
      edge_cnt <= edge_nx;
      bit_cnt  <= bit_nx;
    end
  end

  always_ff @(posedge CLK) begin
    shreg  <= shreg_nx;
    perr_q <= perr_nx;
    ferr_q <= ferr_nx;
    zero_q <= zero_nx;
    if (edge_cnt == smp_lo) s_a <= rx;
    if (edge_cnt == half)   s_b <= rx;
    if (latch) begin
      nbits_q    <= data_bits;
      par_en_q   <= parity_enable;
      par_type_q <= parity_type;
      stop2_q    <= stop_bits;
      presc_q    <= Prescale;
    end
  end

  // Bit-end handling comes first so a decision in the same cycle (Prescale 4) overrides it.
  always_comb begin
    state_nx  = state;
    edge_nx   = bit_end ? '0 : edge_cnt + 1'b1;
    bit_nx    = bit_cnt;
    shreg_nx  = shreg;
    perr_nx   = perr_q;
    ferr_nx   = ferr_q;
    zero_nx   = zero_q;
    push      = 1'b0;
    break_det = 1'b0;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        edge_nx = '0;
        bit_nx  = '0;
        if (!rx) begin
          state_nx = S_START;
          latch    = 1'b1;
          shreg_nx = '0;
          perr_nx  = 1'b0;
          ferr_nx  = 1'b0;
          zero_nx  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_nx = S_DATA;
        if (decide) begin
          zero_nx = zero_q & ~maj;
          if (maj) state_nx = S_IDLE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == nbits_q - 1'b1) begin
            bit_nx   = '0;
            state_nx = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
        if (decide) begin
          zero_nx = zero_q & ~maj;
          for (int i = 0; i < DATA_WIDTH; i++)
            if (bit_cnt == i[3:0]) shreg_nx[i] = maj;
        end
      end
      S_PARITY: begin
        if (bit_end) state_nx = S_STOP;
        if (decide) begin
          zero_nx = zero_q & ~maj;
          perr_nx = (maj != ((^shreg) ^ par_type_q));
        end
      end
      S_STOP: begin
        if (bit_end) bit_nx = bit_cnt + 1'b1;
        if (decide) begin
          if (bit_cnt == 4'd0 && zero_q && !maj) begin
            break_det = 1'b1;
            state_nx  = S_BREAK;
            edge_nx   = '0;
          end else begin
            if (!maj) ferr_nx = 1'b1;
            if (bit_cnt == {3'b000, stop2_q}) begin
              push     = 1'b1;
              state_nx = S_IDLE;
            end
          end
        end
      end
      S_BREAK: begin
        // Leave only after a full bit period of continuous idle line.
        if (!rx) edge_nx = '0;
        else if (bit_end) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .push   (push),
    .din    (push_entry),
    .ready  (rx_ready),
    .dout   (head),
    .valid  (rx_valid),
    .overrun(overrun)
  );

  assign rx_data       = head[DATA_WIDTH-1:0];
  assign parity_error  = head[DATA_WIDTH];
  assign framing_error = head[DATA_WIDTH+1];

endmodule
